i2c_slave_ctrl: RTL and testbench
=================================

// Module: i2c_slave_ctrl
// PURPOSE
//  Bit-level I2C slave control unit for the TMP10x sensor model. Samples SCL/SDA with clk,
//  detects START/STOP, shifts address/data bytes, drives ACK and read data onto SDA.
//  Sequences the slave memory: presents the address, checks address-found, pulses its
//  Enable with RorW for each byte. Sits between the I2C pads and the memory block.
// PARAMETERS
//  ADDRESSLENGTH   7     slave address width (address byte = {addr, R/W})
//  SYNC_STAGES     2     synchroniser flops on scl_in/sda_in (>=2)
//  TIMEOUT_CYCLES  4096  clk cycles with no SCL edge in a non-IDLE state before abort
// PORTS
//  clk             in   1   system clock, >= 8x SCL frequency
//  rst_n           in   1   asynchronous active-low reset
//  scl_in          in   1   raw SCL pad input
//  sda_in          in   1   raw SDA pad input
//  sda_oe          out  1   1 = pull SDA low (open drain); 0 = release
//  mem_addr        out  ADDRESSLENGTH  address to memory comparator (DirectionBuffer)
//  mem_addr_found  in   1   memory comparator result for mem_addr
//  mem_enable      out  1   one-cycle pulse; memory transfers on its rising edge
//  mem_rorw        out  1   1 = write mem_wdata to memory, 0 = load mem_rdata
//  mem_wdata       out  8   byte received from master (InputBuffer)
//  mem_rdata       in   8   byte to send to master (OutputBuffer)
//  busy            out  1   1 from START until STOP/abort
//  timeout         out  1   one-cycle pulse when TIMEOUT_CYCLES abort fires
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, shift reg 0, bit count 0, timeout counter 0.
//  Input path: SYNC_STAGES flops + 1 edge-detect flop; an SCL/SDA pad edge is acted on
//   SYNC_STAGES+1 clk later. START = SDA fall while SCL high; STOP = SDA rise while SCL high.
//  START/repeated START in any state -> ADDR, bit count 0, sda_oe 0, busy 1.
//  STOP in any state -> IDLE, sda_oe 0, busy 0. No memory pulse on STOP.
//  Data sampled on SCL rise, MSB first; sda_oe changed only on SCL fall (SDA stable while SCL high).
//  States: IDLE, ADDR, ADDR_CHK, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK, WAIT_STOP.
//  ADDR: 8 rises; after 8th, mem_addr <= byte[7:1], rw <= byte[0] -> ADDR_CHK.
//  ADDR_CHK: wait 2 clk for comparator; found -> ADDR_ACK; else WAIT_STOP (SDA never driven).
//  ADDR_ACK: sda_oe=1 from next SCL fall to following SCL fall; then rw=0 -> WR_DATA,
//   rw=1 -> RD_LOAD.
//  WR_DATA: 8 rises; after 8th: mem_wdata <= byte, mem_rorw=1, mem_enable=1 for 1 clk -> WR_ACK.
//  WR_ACK: drive ACK for 9th bit as ADDR_ACK -> WR_DATA. Extra bytes always ACKed.
//  RD_LOAD: mem_rorw=0, mem_enable 1 clk; capture mem_rdata 2 clk later into shift reg -> RD_DATA.
//   Must complete before next SCL fall (guaranteed by clk >= 8x SCL).
//  RD_DATA: on each SCL fall sda_oe = ~bit (drive only 0s), 8 bits; after 8th fall release -> RD_ACK.
//  RD_ACK: sample SDA on 9th rise: 0 (ACK) -> RD_LOAD; 1 (NACK) -> WAIT_STOP.
//  WAIT_STOP: sda_oe 0, ignore bits; leave only on START/STOP/timeout.
//  mem_addr held stable from ADDR_CHK until next address byte completes (no spurious changes;
//   memory resets its byte counter on address change). mem_enable never high 2 consecutive clk.
//  Timeout: counter clears on every SCL edge and in IDLE; reaching TIMEOUT_CYCLES in any other
//   state -> IDLE, sda_oe 0, busy 0, timeout pulse 1 clk.
//  Simultaneous START and timeout in same clk: START wins. Reset mid-transfer: sda_oe drops
//   asynchronously, no mem_enable pulse.
// TESTING
//  1 Write 0x90 (addr 0x48,W), data 0x60, STOP -> ACK bits 0,0; one mem_enable pulse, rorw=1,
//    mem_wdata=0x60; busy 1->0 at STOP.
//  2 Read 0x91, mem_rdata 0x19 then 0x80, master ACK then NACK -> SDA bytes 0x19,0x80; exactly
//    2 enable pulses, rorw=0; WAIT_STOP after NACK.
//  3 Address 0x94 with found=0 -> SDA never driven, no enable pulse, data bytes ignored till STOP.
//  4 Write 0x90, 0x01, repeated START, read 0x91 -> 1 write pulse then read pulse; mem_addr=0x48
//    held throughout.
//  5 SCL frozen high for TIMEOUT_CYCLES mid-read -> timeout pulse, sda_oe 0, IDLE.
//  6 rst_n low while sda_oe=1 in RD_DATA -> sda_oe 0 same cycle, all outputs 0, next START works.

Source files
------------

// File: rtl/i2c_slave_ctrl.sv
// Bit-level I2C slave controller. Synchronises SCL/SDA, decodes START/STOP, shifts bytes,
// drives ACK and read data onto SDA, and sequences the slave memory with enable/rorw pulses.
module i2c_slave_ctrl #(
  parameter int ADDRESSLENGTH  = 7,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     scl_in,
  input  logic                     sda_in,
  output logic                     sda_oe,
  output logic [ADDRESSLENGTH-1:0] mem_addr,
  input  logic                     mem_addr_found,
  output logic                     mem_enable,
  output logic                     mem_rorw,
  output logic [7:0]               mem_wdata,
  input  logic [7:0]               mem_rdata,
  output logic                     busy,
  output logic                     timeout
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_CHK, ST_ADDR_ACK, ST_WR_DATA,
    ST_WR_ACK, ST_RD_LOAD, ST_RD_DATA, ST_RD_ACK, ST_WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda, w_scl_rise, w_scl_fall, w_scl_edge, w_start, w_stop;
  logic [7:0]             w_byte;

  state_t                 r_state, w_state_nxt;
  logic [7:0]             r_shift, w_shift_nxt;
  logic [3:0]             r_bit_cnt, w_bit_cnt_nxt;
  logic [1:0]             r_wait, w_wait_nxt;
  logic                   r_rw, w_rw_nxt;
  logic [TMO_W-1:0]       r_tmo_cnt, w_tmo_cnt_nxt;
  logic                   r_sda_oe, w_sda_oe_nxt;
  logic [ADDRESSLENGTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic                   r_mem_enable, w_mem_enable_nxt;
  logic                   r_mem_rorw, w_mem_rorw_nxt;
  logic [7:0]             r_mem_wdata, w_mem_wdata_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_timeout, w_timeout_nxt;

  // Synchronisers come out of reset at the idle bus level so reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
      r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_scl_edge = w_scl ^ r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte     = {r_shift[6:0], w_sda};

  // NOTE: every register is updated with <= so all flops see pre-edge values in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_wait       <= '0;
      r_rw         <= 1'b0;
      r_tmo_cnt    <= '0;
      r_sda_oe     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_enable <= 1'b0;
      r_mem_rorw   <= 1'b0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_wait       <= w_wait_nxt;
      r_rw         <= w_rw_nxt;
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      r_sda_oe     <= w_sda_oe_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_enable <= w_mem_enable_nxt;
      r_mem_rorw   <= w_mem_rorw_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_busy       <= w_busy_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_wait_nxt       = r_wait;
    w_rw_nxt         = r_rw;
    w_sda_oe_nxt     = r_sda_oe;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_enable_nxt = 1'b0;
    w_mem_rorw_nxt   = r_mem_rorw;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_busy_nxt       = r_busy;
    w_timeout_nxt    = 1'b0;
    w_tmo_cnt_nxt    = (r_state == ST_IDLE || w_scl_edge) ? '0 : r_tmo_cnt + TMO_W'(1);

    if (w_start) begin
      w_state_nxt   = ST_ADDR;
      w_bit_cnt_nxt = '0;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b1;
      w_tmo_cnt_nxt = '0;
    end else if (w_stop) begin
      w_state_nxt   = ST_IDLE;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
      w_tmo_cnt_nxt = '0;
    end else if (r_state != ST_IDLE && !w_scl_edge && r_tmo_cnt == TMO_LAST) begin
      w_state_nxt   = ST_IDLE;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
      w_timeout_nxt = 1'b1;
      w_tmo_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: ;
        ST_ADDR: if (w_scl_rise) begin
          w_shift_nxt = w_byte;
          if (r_bit_cnt == 4'd7) begin
            // Upper bits of the address byte form the address; bit 0 is R/W.
            w_mem_addr_nxt = w_byte[7 -: ADDRESSLENGTH];
            w_rw_nxt       = w_byte[0];
            w_bit_cnt_nxt  = '0;
            w_wait_nxt     = '0;
            w_state_nxt    = ST_ADDR_CHK;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
        ST_ADDR_CHK: begin
          if (r_wait == 2'd1)
            w_state_nxt = mem_addr_found ? ST_ADDR_ACK : ST_WAIT_STOP;
          else
            w_wait_nxt = r_wait + 2'd1;
        end
        ST_ADDR_ACK, ST_WR_ACK: if (w_scl_fall) begin
          // First fall starts the ACK low, the next one ends it.
          if (!r_sda_oe) begin
            w_sda_oe_nxt = 1'b1;
          end else begin
            w_sda_oe_nxt  = 1'b0;
            w_bit_cnt_nxt = '0;
            if (r_state == ST_WR_ACK || !r_rw) begin
              w_state_nxt = ST_WR_DATA;
            end else begin
              w_state_nxt      = ST_RD_LOAD;
              w_mem_enable_nxt = 1'b1;
              w_mem_rorw_nxt   = 1'b0;
              w_wait_nxt       = '0;
            end
          end
        end
        ST_WR_DATA: if (w_scl_rise) begin
          w_shift_nxt = w_byte;
          if (r_bit_cnt == 4'd7) begin
            w_mem_wdata_nxt  = w_byte;
            w_mem_rorw_nxt   = 1'b1;
            w_mem_enable_nxt = 1'b1;
            w_bit_cnt_nxt    = '0;
            w_state_nxt      = ST_WR_ACK;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
        ST_RD_LOAD: begin
          // Capture two clk after the enable edge, then present bit 7 once SCL is low.
          if (r_wait == 2'd0) begin
            w_wait_nxt = 2'd1;
          end else if (r_wait == 2'd1) begin
            w_shift_nxt = mem_rdata;
            w_wait_nxt  = 2'd2;
          end else if (!w_scl) begin
            w_sda_oe_nxt  = ~r_shift[7];
            w_bit_cnt_nxt = 4'd1;
            w_state_nxt   = ST_RD_DATA;
          end
        end
        ST_RD_DATA: if (w_scl_fall) begin
          if (r_bit_cnt == 4'd8) begin
            w_sda_oe_nxt  = 1'b0;
            w_bit_cnt_nxt = '0;
            w_state_nxt   = ST_RD_ACK;
          end else begin
            w_sda_oe_nxt  = ~r_shift[6];
            w_shift_nxt   = {r_shift[6:0], 1'b0};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
        ST_RD_ACK: if (w_scl_rise) begin
          if (!w_sda) begin
            w_state_nxt      = ST_RD_LOAD;
            w_mem_enable_nxt = 1'b1;
            w_mem_rorw_nxt   = 1'b0;
            w_wait_nxt       = '0;
          end else begin
            w_state_nxt = ST_WAIT_STOP;
          end
        end
        ST_WAIT_STOP: w_sda_oe_nxt = 1'b0;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign sda_oe     = r_sda_oe;
  assign mem_addr   = r_mem_addr;
  assign mem_enable = r_mem_enable;
  assign mem_rorw   = r_mem_rorw;
  assign mem_wdata  = r_mem_wdata;
  assign busy       = r_busy;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: a bit-banged I2C master, a small memory model that
// answers at address 0x48, and hand-computed expectations for write, read, NACK and abort cases.
module tb_i2c_slave_ctrl;
  localparam int TMO = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_oe, mem_enable, mem_rorw, busy, timeout;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  wire        sda_bus = m_sda & ~sda_oe;
  wire        mem_addr_found = (mem_addr == 7'h48);

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt = 0, dbl_en = 0, tmo_cnt = 0, addr_chg = 0, oe_cnt = 0, rd_idx = 0;
  logic       prev_en = 1'b0;
  logic [6:0] prev_addr = 7'h00;
  logic       pulse_rorw [0:31];
  logic [7:0] rd_tbl [0:7];

  i2c_slave_ctrl #(.ADDRESSLENGTH(7), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(m_scl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .mem_addr(mem_addr), .mem_addr_found(mem_addr_found), .mem_enable(mem_enable),
    .mem_rorw(mem_rorw), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Memory model and event counters, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (mem_enable) begin
      if (en_cnt < 32) pulse_rorw[en_cnt] = mem_rorw;
      en_cnt++;
      if (prev_en) dbl_en++;
      if (!mem_rorw) begin
        mem_rdata = rd_tbl[rd_idx & 7];
        rd_idx++;
      end
    end
    prev_en = mem_enable;
    if (timeout) tmo_cnt++;
    if (sda_oe) oe_cnt++;
    if (mem_addr != prev_addr) addr_chg++;
    prev_addr = mem_addr;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period: 8 clk low then 8 clk high; SDA is sampled mid-high.
  task automatic clk_bit(input logic v, output logic s);
    wait_clk(4); m_sda = v;
    wait_clk(4); m_scl = 1'b1;
    wait_clk(4); s = sda_bus;
    wait_clk(4); m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clk(4); m_sda = 1'b1;
    wait_clk(4); m_scl = 1'b1;
    wait_clk(8); m_sda = 1'b0;
    wait_clk(8); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(4); m_sda = 1'b0;
    wait_clk(4); m_scl = 1'b1;
    wait_clk(8); m_sda = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic m_ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(m_ack, s);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;
    int         base, cbase, obase, tbase;

    rd_tbl[0] = 8'h19; rd_tbl[1] = 8'h80; rd_tbl[2] = 8'h5A; rd_tbl[3] = 8'h19;
    rd_tbl[4] = 8'h19; rd_tbl[5] = 8'h00; rd_tbl[6] = 8'h00; rd_tbl[7] = 8'h00;

    wait_clk(4);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_enable", mem_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_rorw", mem_rorw, 0);
    check("rst_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    wait_clk(8);

    // 1: write 0x60 to slave 0x48
    base = en_cnt;
    i2c_start();
    send_byte(8'h90, ack); check("t1_addr_ack", ack, 0);
    send_byte(8'h60, ack); check("t1_data_ack", ack, 0);
    check("t1_busy_before_stop", busy, 1);
    i2c_stop();
    check("t1_busy_after_stop", busy, 0);
    check("t1_enable_pulses", en_cnt - base, 1);
    check("t1_rorw", pulse_rorw[base], 1);
    check("t1_wdata", mem_wdata, 8'h60);
    check("t1_addr", mem_addr, 7'h48);

    // 2: read two bytes, ACK then NACK
    base = en_cnt;
    i2c_start();
    send_byte(8'h91, ack); check("t2_addr_ack", ack, 0);
    recv_byte(rb, 1'b0); check("t2_byte0", rb, 8'h19);
    recv_byte(rb, 1'b1); check("t2_byte1", rb, 8'h80);
    check("t2_enable_pulses", en_cnt - base, 2);
    check("t2_rorw0", pulse_rorw[base], 0);
    check("t2_rorw1", pulse_rorw[base+1], 0);
    obase = oe_cnt;
    send_byte(8'h00, ack);
    check("t2_wait_stop_quiet", oe_cnt - obase, 0);
    check("t2_busy_wait_stop", busy, 1);
    i2c_stop();
    check("t2_busy_after_stop", busy, 0);

    // 3: unknown address 0x4A is never acknowledged
    base = en_cnt; obase = oe_cnt;
    i2c_start();
    send_byte(8'h94, ack); check("t3_addr_nack", ack, 1);
    check("t3_addr", mem_addr, 7'h4A);
    send_byte(8'h55, ack); check("t3_data_nack", ack, 1);
    check("t3_busy", busy, 1);
    i2c_stop();
    check("t3_busy_after_stop", busy, 0);
    check("t3_no_enable", en_cnt - base, 0);
    check("t3_sda_never_driven", oe_cnt - obase, 0);

    // 4: write, repeated START, read
    base = en_cnt; cbase = addr_chg;
    i2c_start();
    send_byte(8'h90, ack); check("t4_waddr_ack", ack, 0);
    send_byte(8'h01, ack); check("t4_data_ack", ack, 0);
    i2c_start();
    send_byte(8'h91, ack); check("t4_raddr_ack", ack, 0);
    recv_byte(rb, 1'b1); check("t4_rbyte", rb, 8'h5A);
    i2c_stop();
    check("t4_enable_pulses", en_cnt - base, 2);
    check("t4_first_is_write", pulse_rorw[base], 1);
    check("t4_second_is_read", pulse_rorw[base+1], 0);
    check("t4_wdata", mem_wdata, 8'h01);
    check("t4_addr", mem_addr, 7'h48);
    check("t4_addr_changes", addr_chg - cbase, 1);

    // 5: SCL frozen high in the middle of a read
    i2c_start();
    send_byte(8'h91, ack); check("t5_addr_ack", ack, 0);
    clk_bit(1'b1, rb[7]); check("t5_bit7", rb[7], 0);
    wait_clk(4); m_scl = 1'b1;
    tbase = tmo_cnt;
    wait_clk(100);
    check("t5_busy_early", busy, 1);
    check("t5_driving_early", sda_oe, 1);
    check("t5_no_early_timeout", tmo_cnt - tbase, 0);
    for (int i = 0; i < 400 && tmo_cnt == tbase; i++) wait_clk(1);
    check("t5_timeout_seen", tmo_cnt - tbase, 1);
    wait_clk(2);
    check("t5_sda_released", sda_oe, 0);
    check("t5_busy_cleared", busy, 0);
    wait_clk(20);
    check("t5_single_pulse", tmo_cnt - tbase, 1);

    // 6: reset while driving read data
    i2c_start();
    send_byte(8'h91, ack); check("t6_addr_ack", ack, 0);
    for (int i = 0; i < 20 && !sda_oe; i++) wait_clk(1);
    check("t6_driving", sda_oe, 1);
    base = en_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_sda_oe", sda_oe, 0);
    check("t6_busy", busy, 0);
    check("t6_addr", mem_addr, 0);
    check("t6_wdata", mem_wdata, 0);
    m_scl = 1'b1; m_sda = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(8);
    check("t6_no_enable_in_reset", en_cnt - base, 0);
    base = en_cnt;
    i2c_start();
    send_byte(8'h90, ack); check("t6_post_addr_ack", ack, 0);
    send_byte(8'h60, ack); check("t6_post_data_ack", ack, 0);
    i2c_stop();
    check("t6_post_enable", en_cnt - base, 1);
    check("t6_post_wdata", mem_wdata, 8'h60);

    check("enable_never_back_to_back", dbl_en, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
